uart_tx_frame_ctrl: RTL and testbench
=====================================

Name: uart_tx_frame_ctrl

Overview:
Sequencer for the UART transmitter datapath. It accepts a byte plus its framing configuration, latches them, and serialises one frame onto tx_out: start bit, 8 data bits LSB-first, an optional parity bit, and 1 or 2 stop bits. Bit timing comes from an internal clocks-per-bit counter. The parity bit is computed from the latched byte using the team's standard parity_type encoding.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
tx_start  input  1  request to send; sampled every cycle.
data_in  input  8  byte to transmit; latched on accept.
parity_type  input  2  00 = none, 01 = odd, 10 = even, 11 = none; latched on accept.
stop_bits  input  1  0 = one stop bit, 1 = two stop bits; latched on accept.
tx_out  output  1  serial line, idle high.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered. While rst = 1 at a clock edge:
  - state <= IDLE; bit and clock counters <= 0.
  - tx_out <= 1, busy <= 0, done <= 0.
- Reset applied mid-frame aborts the frame. tx_out returns to 1 at the next edge and no done pulse is produced.
- Accept condition: tx_start = 1 while state = IDLE. At that edge:
  - latch data_in into the shift register; latch parity_type and stop_bits.
  - state <= START, tx_out <= 0, busy <= 1, clock counter <= 0.
- tx_start while busy is ignored; there is no queueing.
- Later changes to data_in, parity_type or stop_bits have no effect on the frame in flight.
- Every bit lasts exactly CLKS_PER_BIT cycles. The clock counter counts 0 to CLKS_PER_BIT-1; the state action happens on the edge where the counter equals CLKS_PER_BIT-1 (end of bit), and the counter then wraps to 0.
- State transitions at end of bit:
  - START -> DATA: tx_out <= shreg[0]; bit counter <= 0.
  - DATA, bit counter < 7: shift right, tx_out <= next bit, bit counter +1.
  - DATA, bit counter = 7, parity enabled (01 or 10): PARITY, with tx_out <= parity bit.
  - DATA, bit counter = 7, parity disabled (00 or 11): STOP, with tx_out <= 1.
  - PARITY -> STOP: tx_out <= 1; stop counter <= 0.
  - STOP, two stop bits and stop counter = 0: stay in STOP; stop counter <= 1.
  - STOP, otherwise: IDLE; busy <= 0, done <= 1 for one cycle; tx_out remains 1.
- Parity bit is computed on the latched byte:
  - 01 (odd): XNOR-reduce of the byte, so the count of ones in data plus parity is odd.
  - 10 (even): XOR-reduce of the byte.
- Frame length from accept edge to the done edge: (1 + 8 + P + S) * CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
- Back-to-back frames: tx_start = 1 in the cycle where done = 1 (state already IDLE) is accepted. tx_out goes 0 at that edge; there are no extra idle cycles between frames.
- done and busy are never high in the same cycle.
- The IDLE state has no timing requirement on tx_start hold length; a single-cycle pulse is sufficient.

Test Plan:
- Reset, then idle for 20 cycles -> tx_out = 1, busy = 0, done = 0 throughout.
- CLKS_PER_BIT = 4; send 0x55 with parity_type = 10 and stop_bits = 0 -> each bit held 4 cycles:
  - line sequence 0, 1,0,1,0,1,0,1,0, parity 0, stop 1;
  - done pulses 44 cycles after accept.
- Send 0x07 with parity_type = 01, then again with 10 -> parity bit 0, then 1. Send with 00 and 11 -> no parity bit; frame = 40 cycles.
- Send 0xA3 with stop_bits = 1 and parity_type = 00 -> stop high for 8 cycles; done at cycle 44. A tx_start pulse mid-frame leaves the frame unchanged.
- Hold tx_start = 1 continuously with 0x0F and then 0xF0 -> the second start bit begins the cycle done pulses; no idle gap appears on tx_out.
- Assert rst during data bit 3 -> next cycle tx_out = 1 and busy = 0, with no done pulse. A new tx_start after reset produces a correct full frame.

Source files
------------

// File: rtl/uart_tx_frame_ctrl_if.sv
// Handshake and serial-line bundle for the UART transmit frame sequencer.
// The master side requests frames and supplies framing configuration;
// the slave side is the sequencer that drives the line and status flags.
interface uart_tx_frame_ctrl_if;
    logic       tx_start;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       tx_out;
    logic       busy;
    logic       done;

    modport master (
        output tx_start, data_in, parity_type, stop_bits,
        input  tx_out, busy, done
    );

    modport slave (
        input  tx_start, data_in, parity_type, stop_bits,
        output tx_out, busy, done
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: latches a byte and its framing options,
// then drives start bit, 8 data bits LSB-first, optional parity and one or
// two stop bits onto the serial line, each bit lasting CLKS_PER_BIT clocks.
// CLKS_PER_BIT must be 2 or more.
module uart_tx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_frame_ctrl_if.slave  bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;

    txState_t         state_q,     state_d;
    logic [7:0]       shiftReg_q,  shiftReg_d;
    logic             parityEn_q,  parityEn_d;
    logic             parityBit_q, parityBit_d;
    logic             stopTwo_q,   stopTwo_d;
    logic [CNT_W-1:0] clkCnt_q,    clkCnt_d;
    logic [2:0]       bitCnt_q,    bitCnt_d;
    logic             stopCnt_q,   stopCnt_d;
    logic             txOut_q,     txOut_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic             endOfBit;

    assign endOfBit    = (clkCnt_q == LAST_CNT);

    assign bus.tx_out  = txOut_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // State register: every output is taken straight from a flop, and reset
    // forces an idle line, clears the counters and drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            parityEn_q  <= 1'b0;
            parityBit_q <= 1'b0;
            stopTwo_q   <= 1'b0;
            clkCnt_q    <= '0;
            bitCnt_q    <= '0;
            stopCnt_q   <= 1'b0;
            txOut_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shiftReg_q  <= shiftReg_d;
            parityEn_q  <= parityEn_d;
            parityBit_q <= parityBit_d;
            stopTwo_q   <= stopTwo_d;
            clkCnt_q    <= clkCnt_d;
            bitCnt_q    <= bitCnt_d;
            stopCnt_q   <= stopCnt_d;
            txOut_q     <= txOut_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: accept in IDLE, otherwise advance the bit timer and
    // act only at the end of each bit. The parity bit is resolved from the
    // byte at accept time since the shift register is consumed by shifting.
    always_comb begin
        state_d     = state_q;
        shiftReg_d  = shiftReg_q;
        parityEn_d  = parityEn_q;
        parityBit_d = parityBit_q;
        stopTwo_d   = stopTwo_q;
        clkCnt_d    = clkCnt_q;
        bitCnt_d    = bitCnt_q;
        stopCnt_d   = stopCnt_q;
        txOut_d     = txOut_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (state_q != IDLE) begin
            clkCnt_d = endOfBit ? '0 : clkCnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                clkCnt_d = '0;
                if (bus.tx_start) begin
                    shiftReg_d  = bus.data_in;
                    parityEn_d  = (bus.parity_type == 2'b01) ||
                                  (bus.parity_type == 2'b10);
                    parityBit_d = (bus.parity_type == 2'b01) ? ~^bus.data_in
                                                             :  ^bus.data_in;
                    stopTwo_d   = bus.stop_bits;
                    state_d     = START;
                    txOut_d     = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            START: begin
                if (endOfBit) begin
                    state_d  = DATA;
                    txOut_d  = shiftReg_q[0];
                    bitCnt_d = '0;
                end
            end
            DATA: begin
                if (endOfBit) begin
                    if (bitCnt_q != 3'd7) begin
                        shiftReg_d = {1'b0, shiftReg_q[7:1]};
                        txOut_d    = shiftReg_q[1];
                        bitCnt_d   = bitCnt_q + 3'd1;
                    end else if (parityEn_q) begin
                        state_d = PARITY;
                        txOut_d = parityBit_q;
                    end else begin
                        state_d   = STOP;
                        txOut_d   = 1'b1;
                        stopCnt_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (endOfBit) begin
                    state_d   = STOP;
                    txOut_d   = 1'b1;
                    stopCnt_d = 1'b0;
                end
            end
            STOP: begin
                if (endOfBit) begin
                    if (stopTwo_q && !stopCnt_q) begin
                        stopCnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        txOut_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txOut_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl. A reference model turns each
// accepted frame into the list of line levels it should produce, one entry
// per clock, and every cycle the line, busy and done are compared against it.
module tb_uart_tx_frame_ctrl;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;

    uart_tx_frame_ctrl_if bus ();

    uart_tx_frame_ctrl #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int   numChecks  = 0;
    int   numFails   = 0;
    int   edgeNum    = 0;
    int   acceptEdge = 0;
    int   expLen     = 0;
    bit   modelBusy  = 1'b0;
    bit   expLine[$];
    logic expTx;
    logic expBusy;
    logic expDone;

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (edge %0d)",
                     tag, observed, expected, edgeNum);
        end
    endtask

    // Frame as a list of serial bits, then stretched to one entry per clock.
    task automatic buildFrame(input logic [7:0] d, input logic [1:0] p,
                              input logic sb);
        bit bits[$];
        int ones;
        ones = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (p == 2'b01) bits.push_back(bit'((ones % 2) == 0));
        if (p == 2'b10) bits.push_back(bit'((ones % 2) == 1));
        bits.push_back(1'b1);
        if (sb) bits.push_back(1'b1);
        expLine.delete();
        foreach (bits[i]) begin
            for (int k = 0; k < CPB; k++) expLine.push_back(bits[i]);
        end
        expLen = bits.size() * CPB;
    endtask

    // Advance the reference model by one clock edge using the inputs sampled there.
    task automatic modelStep();
        edgeNum++;
        expDone = 1'b0;
        if (rst) begin
            expLine.delete();
            modelBusy = 1'b0;
            expTx     = 1'b1;
            expBusy   = 1'b0;
        end else if (modelBusy) begin
            if (expLine.size() > 0) begin
                expTx   = expLine.pop_front();
                expBusy = 1'b1;
            end else begin
                modelBusy = 1'b0;
                expTx     = 1'b1;
                expBusy   = 1'b0;
                expDone   = 1'b1;
            end
        end else if (bus.tx_start) begin
            buildFrame(bus.data_in, bus.parity_type, bus.stop_bits);
            acceptEdge = edgeNum;
            modelBusy  = 1'b1;
            expTx      = expLine.pop_front();
            expBusy    = 1'b1;
        end else begin
            expTx   = 1'b1;
            expBusy = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare outputs just after the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d,
                                 input logic [1:0] p, input logic sb);
        rst             = r;
        bus.tx_start    = s;
        bus.data_in     = d;
        bus.parity_type = p;
        bus.stop_bits   = sb;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("tx_out", 32'(bus.tx_out), 32'(expTx));
        checkOutput("busy",   32'(bus.busy),   32'(expBusy));
        checkOutput("done",   32'(bus.done),   32'(expDone));
        checkOutput("busyDoneExclusive", 32'(bus.busy & bus.done), 32'd0);
        if (bus.done === 1'b1) begin
            checkOutput("frameLen", 32'(edgeNum - acceptEdge), 32'(expLen));
        end
    endtask

    // One cycle with no reset and scrambled frame configuration.
    task automatic randCycle(input logic s);
        applyStimulus(1'b0, s, 8'($urandom), 2'($urandom), 1'($urandom));
    endtask

    // Pulse tx_start for one cycle, then run the whole frame plus one idle
    // cycle while scrambling the inputs; an optional stray start pulse lands mid-frame.
    task automatic sendFrame(input logic [7:0] d, input logic [1:0] p,
                             input logic sb, input int glitchAt);
        applyStimulus(1'b0, 1'b1, d, p, sb);
        for (int i = 0; i < expLen + 1; i++) randCycle(i == glitchAt);
    endtask

    initial begin
        rst             = 1'b1;
        bus.tx_start    = 1'b0;
        bus.data_in     = '0;
        bus.parity_type = '0;
        bus.stop_bits   = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        repeat (20) randCycle(1'b0);

        sendFrame(8'h55, 2'b10, 1'b0, 10);
        sendFrame(8'h07, 2'b01, 1'b0, -1);
        sendFrame(8'h07, 2'b10, 1'b0, -1);
        sendFrame(8'h07, 2'b00, 1'b0, -1);
        sendFrame(8'h07, 2'b11, 1'b0, -1);
        sendFrame(8'hA3, 2'b00, 1'b1, 20);

        applyStimulus(1'b0, 1'b1, 8'h0F, 2'b00, 1'b0);
        for (int i = 0; i < 85; i++) applyStimulus(1'b0, 1'b1, 8'hF0, 2'b00, 1'b0);
        repeat (45) randCycle(1'b0);

        applyStimulus(1'b0, 1'b1, 8'h3C, 2'b10, 1'b1);
        repeat (17) randCycle(1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        repeat (3) randCycle(1'b0);
        sendFrame(8'hC5, 2'b01, 1'b1, -1);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'($urandom_range(0, 599) == 0),
                          1'($urandom_range(0, 7) == 0),
                          8'($urandom), 2'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0),
                          8'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 numChecks, numFails);
        $finish;
    end

endmodule
